// File: rtl/hilo_div.sv
// hilo_div: radix-2 restoring signed/unsigned divider for the HI/LO path. Rev 1.0
// Optional feature: define HILO_DIV_ZERO_EN for a 1-cycle zero-divisor result with div_zero_o.
`default_nettype none

module hilo_div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     div_q, div_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 sgn_q, sgn_d;
  logic                 neg1_q, neg1_d;
  logic                 neg2_q, neg2_d;
  logic                 zero_q, zero_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
`ifdef HILO_DIV_ZERO_EN
  logic                 dz_q, dz_d;
`endif

  logic [WIDTH-1:0]     op1_mag, op2_mag, rem_next, q_next, quot_fix, rem_fix;
  logic [WIDTH:0]       rem_trial;
  logic                 trial_ge, op2_zero;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    div_d    = div_q;
    rem_d    = rem_q;
    sgn_d    = sgn_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    zero_d   = zero_q;
    result_d = result_q;
`ifdef HILO_DIV_ZERO_EN
    dz_d     = dz_q;
`endif

    op1_mag  = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    op2_mag  = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    op2_zero = (opdata2_i == '0);

    // The dividend register doubles as the quotient shift register.
    rem_trial = {rem_q, quo_q[WIDTH-1]};
    trial_ge  = (rem_trial >= {1'b0, div_q});
    rem_next  = trial_ge ? (rem_trial[WIDTH-1:0] - div_q) : rem_trial[WIDTH-1:0];
    q_next    = {quo_q[WIDTH-2:0], trial_ge};
    quot_fix  = (sgn_q && (neg1_q ^ neg2_q)) ? -q_next : q_next;
    rem_fix   = (sgn_q && neg1_q) ? -rem_next : rem_next;

    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          rem_d   = '0;
          sgn_d   = signed_i;
          neg1_d  = signed_i & opdata1_i[WIDTH-1];
          neg2_d  = signed_i & opdata2_i[WIDTH-1];
          zero_d  = op2_zero;
          // A zero divisor keeps the raw dividend so it falls out as the remainder.
          quo_d   = op2_zero ? opdata1_i : op1_mag;
          div_d   = op2_mag;
        end
      end
      S_BUSY: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end
`ifdef HILO_DIV_ZERO_EN
        else if (zero_q) begin
          state_d  = S_DONE;
          result_d = '0;
          dz_d     = 1'b1;
        end
`endif
        else begin
          cnt_d = cnt_q + 1'b1;
          rem_d = rem_next;
          quo_d = q_next;
          if (cnt_q == LAST_STEP) begin
            state_d  = S_DONE;
            result_d = zero_q ? {rem_next, {WIDTH{1'b1}}} : {rem_fix, quot_fix};
          end
        end
      end
      S_DONE: begin
        if (!start_i) begin
          state_d = S_IDLE;
`ifdef HILO_DIV_ZERO_EN
          dz_d    = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      sgn_q    <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
`ifdef HILO_DIV_ZERO_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      sgn_q    <= sgn_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      zero_q   <= zero_d;
      result_q <= result_d;
`ifdef HILO_DIV_ZERO_EN
      dz_q     <= dz_d;
`endif
    end
  end

  assign result_o = result_q;
  assign busy_o   = (state_q == S_BUSY);
  assign ready_o  = (state_q == S_DONE);
`ifdef HILO_DIV_ZERO_EN
  assign div_zero_o = dz_q;
`else
  assign div_zero_o = 1'b0;
`endif

endmodule

`default_nettype wire
